// File: rtl/pipeline_mem.sv
// pipeline_mem: memory stage; one load/store per instruction over req/ack, then holds the writeback record.
// Optional PIPELINE_MEM_MISALIGN_TRAP_EN: misaligned accesses trap to writeback instead of being aligned down.
module pipeline_mem #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ex_res,
    input  logic [DATA_WIDTH-1:0] r2_val_mem,
    input  logic [4:0]            mem_dst_reg,
    input  logic [31:0]           next_mem_opcode,
    input  logic [2:0]            next_mem_operation_size,
    input  logic                  ecall_mem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [7:0]            dmem_wstrb,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_we,
    output logic [4:0]            wb_dst_reg,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ecall,
    output logic                  wb_misaligned
);
    typedef enum logic [1:0] {IDLE, ACCESS, OUT} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] res, sdata, wbd, sh, ld_data;
    logic [4:0] dst;
    logic [1:0] sz;
    logic ld, st, u, ecall, mis;
    logic in_ld, in_st, in_mis, xfer;
    logic [2:0] o, off;
    logic [7:0] strb_base;
    state_t go;

    assign in_ld = next_mem_opcode == 32'd1;
    assign in_st = next_mem_opcode == 32'd2;
    assign in_ready = (state == IDLE) | (state == OUT & wb_ready);
    assign xfer = in_valid & in_ready;
    assign o = res[2:0];
`ifdef PIPELINE_MEM_MISALIGN_TRAP_EN
    assign in_mis = (in_ld | in_st) & (
        (next_mem_operation_size[1:0] == 2'd1 & ex_res[0]) |
        (next_mem_operation_size[1:0] == 2'd2 & |ex_res[1:0]) |
        (next_mem_operation_size[1:0] == 2'd3 & |ex_res[2:0]));
    assign off = o;
    assign wb_misaligned = wb_valid & mis;
`else
    assign in_mis = 1'b0;
    // Silently align the lane offset down to the access size.
    assign off = sz == 2'd1 ? {o[2:1], 1'b0} : sz == 2'd2 ? {o[2], 2'b00} : sz == 2'd3 ? 3'd0 : o;
    assign wb_misaligned = 1'b0;
`endif

    assign go = (in_ld | in_st) & ~in_mis ? ACCESS : OUT;

    always_comb begin
        state_nx = state;
        state_nx = xfer ? go :
                   (state == ACCESS & dmem_ack) ? OUT :
                   (state == OUT & wb_ready) ? IDLE : state;
    end

    assign sh = dmem_rdata >> {off, 3'b000};
    assign ld_data = sz == 2'd0 ? {{56{sh[7] & ~u}}, sh[7:0]} :
                     sz == 2'd1 ? {{48{sh[15] & ~u}}, sh[15:0]} :
                     sz == 2'd2 ? {{32{sh[31] & ~u}}, sh[31:0]} : sh;
    assign strb_base = sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;

    assign dmem_req = state == ACCESS;
    assign dmem_we = dmem_req & st;
    assign dmem_addr = {res[ADDR_WIDTH-1:3], 3'b000};
    assign dmem_wdata = sdata << {off, 3'b000};
    assign dmem_wstrb = strb_base << off;

    assign wb_valid = state == OUT;
    assign wb_we = wb_valid & (dst != 5'd0) & ~st & ~mis;
    assign wb_dst_reg = dst;
    assign wb_data = wbd;
    assign wb_ecall = ecall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            res <= '0;
            sdata <= '0;
            wbd <= '0;
            dst <= '0;
            sz <= '0;
            ld <= 1'b0;
            st <= 1'b0;
            u <= 1'b0;
            ecall <= 1'b0;
            mis <= 1'b0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                res <= ex_res;
                sdata <= r2_val_mem;
                dst <= mem_dst_reg;
                sz <= next_mem_operation_size[1:0];
                u <= next_mem_operation_size[2];
                ld <= in_ld;
                st <= in_st;
                ecall <= ecall_mem;
                mis <= in_mis;
                wbd <= (in_ld | in_st) ? '0 : ex_res;
            end else if (state == ACCESS & dmem_ack) begin
                wbd <= ld ? ld_data : '0;
            end
        end
    end
endmodule
